// File: rtl/md_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: md_op encoding,
// default latencies, a HI/LO pair type and op-class helpers.
package md_unit_pkg;

    localparam int MD_OP_W = 4;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Upper half lands in HI, lower half in LO (product, or remainder/quotient)
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_pair_t;

    function automatic logic is_mult_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage request/response bundle between the pipeline and the md unit.
// The pipeline side is the master; the md unit is the slave.
interface md_unit_if;
    import md_unit_pkg::*;

    logic [MD_OP_W-1:0] md_op;
    logic               start;
    logic [31:0]        A;
    logic [31:0]        B;
    logic               busy;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic [31:0]        md_out;

    modport master (
        output md_op, start, A, B,
        input  busy, hi, lo, md_out
    );

    modport slave (
        input  md_op, start, A, B,
        output busy, hi, lo, md_out
    );

endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage. Runs mult/multu/div/divu with a fixed
// latency, owns HI/LO, and serves mfhi/mflo/mthi/mtlo. The result is computed
// from the operands present on the start edge and held in hi_tmp/lo_tmp until
// the final busy cycle, so operand changes during the run have no effect.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES    = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES     = DIV_CYCLES_DEF,
    parameter bit CHECK_PROTOCOL = 1'b1
) (
    input logic      clk,
    input logic      reset,
    md_unit_if.slave md
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      hi_tmp;
    logic [31:0]      lo_tmp;
    logic             div_by_zero;

    logic signed [63:0] a_sext;
    logic signed [63:0] b_sext;
    logic [63:0]        a_zext;
    logic [63:0]        b_zext;
    md_pair_t           mult_res;
    md_pair_t           multu_res;
    md_pair_t           div_res;
    md_pair_t           divu_res;
    md_pair_t           start_res;

    // Compute every candidate result from the current operands and pick the one for md_op
    always_comb begin
        a_sext    = {{32{md.A[31]}}, md.A};
        b_sext    = {{32{md.B[31]}}, md.B};
        a_zext    = {32'd0, md.A};
        b_zext    = {32'd0, md.B};
        mult_res  = a_sext * b_sext;
        multu_res = a_zext * b_zext;
        div_res   = '0;
        divu_res  = '0;
        if (md.B != 32'd0) begin
            div_res.lo  = $signed(md.A) / $signed(md.B);
            div_res.hi  = $signed(md.A) % $signed(md.B);
            divu_res.lo = md.A / md.B;
            divu_res.hi = md.A % md.B;
        end
        case (md.md_op)
            MD_MULT:  start_res = mult_res;
            MD_MULTU: start_res = multu_res;
            MD_DIV:   start_res = div_res;
            default:  start_res = divu_res;
        endcase
    end

    // IDLE/RUN sequencing: capture the result at start, count down, commit to HI/LO at the last cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            hi_tmp      <= '0;
            lo_tmp      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md.start) begin
                        if (is_mult_op(md.md_op)) begin
                            state       <= ST_RUN;
                            cnt         <= CNT_W'(MULT_CYCLES);
                            hi_tmp      <= start_res.hi;
                            lo_tmp      <= start_res.lo;
                            div_by_zero <= 1'b0;
                        end else if (is_div_op(md.md_op)) begin
                            state       <= ST_RUN;
                            cnt         <= CNT_W'(DIV_CYCLES);
                            hi_tmp      <= start_res.hi;
                            lo_tmp      <= start_res.lo;
                            div_by_zero <= (md.B == 32'd0);
                        end
                    end else if (md.md_op == MD_MTHI) begin
                        hi_q <= md.A;
                    end else if (md.md_op == MD_MTLO) begin
                        lo_q <= md.A;
                    end
                end
                default: begin
                    if (cnt == CNT_W'(1)) begin
                        if (!div_by_zero) begin
                            hi_q <= hi_tmp;
                            lo_q <= lo_tmp;
                        end
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Read port for mfhi/mflo; only committed HI/LO are ever visible here
    always_comb begin
        md.md_out = 32'd0;
        if (md.md_op == MD_MFHI) begin
            md.md_out = hi_q;
        end else if (md.md_op == MD_MFLO) begin
            md.md_out = lo_q;
        end
    end

    assign md.busy = (state == ST_RUN);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

    // Flag requests the hazard unit is meant to keep away from this unit
    always @(posedge clk) begin
        if (CHECK_PROTOCOL && reset) begin
            if (state == ST_RUN) begin
                assert (!md.start);
                assert (md.md_op != MD_MTHI && md.md_op != MD_MTLO);
            end
            assert (!(md.start && !(is_mult_op(md.md_op) || is_div_op(md.md_op))));
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios followed by random traffic, all
// checked each edge against a cycle-level behavioural model of HI/LO.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;

    md_unit_if mdi();

    md_unit #(
        .MULT_CYCLES   (MULT_N),
        .DIV_CYCLES    (DIV_N),
        .CHECK_PROTOCOL(1'b0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (mdi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_dz;
    int          pend_left;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
        mdi.md_op = op;
        mdi.start = st;
        mdi.A     = a;
        mdi.B     = b;
    endtask

    function automatic void model_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int              sa;
        int              sb;
        int unsigned     ua;
        int unsigned     ub;
        longint          sp;
        longint unsigned up;
        sa = int'(a);
        sb = int'(b);
        ua = a;
        ub = b;
        pend_dz = 1'b0;
        case (op)
            MD_MULT: begin
                sp = longint'(sa) * longint'(sb);
                pend_hi = sp[63:32];
                pend_lo = sp[31:0];
            end
            MD_MULTU: begin
                up = ua;
                up = up * ub;
                pend_hi = up[63:32];
                pend_lo = up[31:0];
            end
            MD_DIV: begin
                pend_dz = (b == 32'd0);
                if (!pend_dz) begin
                    pend_lo = sa / sb;
                    pend_hi = sa % sb;
                end
            end
            default: begin
                pend_dz = (b == 32'd0);
                if (!pend_dz) begin
                    pend_lo = ua / ub;
                    pend_hi = ua % ub;
                end
            end
        endcase
    endfunction

    function automatic void model_edge(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
        if (pend_left > 0) begin
            pend_left--;
            if (pend_left == 0 && !pend_dz) begin
                m_hi = pend_hi;
                m_lo = pend_lo;
            end
        end else if (st) begin
            if (op inside {MD_MULT, MD_MULTU}) begin
                model_compute(op, a, b);
                pend_left = MULT_N;
            end else if (op inside {MD_DIV, MD_DIVU}) begin
                model_compute(op, a, b);
                pend_left = DIV_N;
            end
        end else if (op == MD_MTHI) begin
            m_hi = a;
        end else if (op == MD_MTLO) begin
            m_lo = a;
        end
    endfunction

    task automatic tick(input string tag);
        logic [3:0]  op;
        logic        st;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        op = mdi.md_op;
        st = mdi.start;
        a  = mdi.A;
        b  = mdi.B;
        @(posedge clk);
        model_edge(op, st, a, b);
        #1;
        exp_out = (mdi.md_op == MD_MFHI) ? m_hi : ((mdi.md_op == MD_MFLO) ? m_lo : 32'd0);
        check_output({tag, "_busy"}, {31'd0, mdi.busy}, {31'd0, (pend_left > 0)});
        check_output({tag, "_hi"}, mdi.hi, m_hi);
        check_output({tag, "_lo"}, mdi.lo, m_lo);
        check_output({tag, "_mdout"}, mdi.md_out, exp_out);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_busy, input bit noise);
        int n;
        apply_stimulus(op, 1'b1, a, b);
        tick(tag);
        apply_stimulus(MD_NONE, 1'b0, a, b);
        n = 0;
        while (mdi.busy === 1'b1 && n < 40) begin
            n++;
            if (noise) begin
                apply_stimulus(MD_NONE, 1'b0, $urandom, $urandom);
            end
            tick(tag);
        end
        check_output({tag, "_busylen"}, n, exp_busy);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        pend_hi   = 32'd0;
        pend_lo   = 32'd0;
        pend_dz   = 1'b0;
        pend_left = 0;
        reset     = 1'b0;
        apply_stimulus(MD_NONE, 1'b0, 32'd0, 32'd0);

        // Reset state
        #2;
        check_output("rst_busy", {31'd0, mdi.busy}, 32'd0);
        check_output("rst_hi", mdi.hi, 32'd0);
        check_output("rst_lo", mdi.lo, 32'd0);
        check_output("rst_mdout", mdi.md_out, 32'd0);
        #10;
        reset = 1'b1;

        // Signed and unsigned multiply of 0xFFFFFFFE * 3
        run_op("t2_mult", MD_MULT, 32'hFFFFFFFE, 32'd3, MULT_N, 1'b0);
        check_output("t2_mult_hi", mdi.hi, 32'hFFFFFFFF);
        check_output("t2_mult_lo", mdi.lo, 32'hFFFFFFFA);
        run_op("t2_multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, MULT_N, 1'b0);
        check_output("t2_multu_hi", mdi.hi, 32'h00000002);
        check_output("t2_multu_lo", mdi.lo, 32'hFFFFFFFA);

        // Signed divide truncates toward zero, remainder takes sign of A
        run_op("t3_div", MD_DIV, 32'hFFFFFFF9, 32'd2, DIV_N, 1'b0);
        check_output("t3_div_lo", mdi.lo, 32'hFFFFFFFD);
        check_output("t3_div_hi", mdi.hi, 32'hFFFFFFFF);
        run_op("t3_divu", MD_DIVU, 32'd7, 32'd2, DIV_N, 1'b0);
        check_output("t3_divu_lo", mdi.lo, 32'd3);
        check_output("t3_divu_hi", mdi.hi, 32'd1);

        // Divide by zero keeps HI/LO
        apply_stimulus(MD_MTHI, 1'b0, 32'h11, 32'd0);
        tick("t4_mthi");
        apply_stimulus(MD_MTLO, 1'b0, 32'h22, 32'd0);
        tick("t4_mtlo");
        run_op("t4_div0", MD_DIV, 32'd5, 32'd0, DIV_N, 1'b0);
        check_output("t4_div0_hi", mdi.hi, 32'h11);
        check_output("t4_div0_lo", mdi.lo, 32'h22);

        // mthi then mfhi/mflo reads; mtlo during a run is dropped
        apply_stimulus(MD_MTHI, 1'b0, 32'h1234, 32'd0);
        tick("t5_mthi");
        apply_stimulus(MD_MFHI, 1'b0, 32'd0, 32'd0);
        tick("t5_mfhi");
        check_output("t5_mfhi_out", mdi.md_out, 32'h1234);
        apply_stimulus(MD_MFLO, 1'b0, 32'd0, 32'd0);
        tick("t5_mflo");
        check_output("t5_mflo_out", mdi.md_out, 32'h22);
        apply_stimulus(MD_MULT, 1'b1, 32'd3, 32'd4);
        tick("t5_mult");
        apply_stimulus(MD_MTLO, 1'b0, 32'hDEADBEEF, 32'd0);
        tick("t5_mtlo_run");
        apply_stimulus(MD_NONE, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 20 && pend_left > 0; i++) tick("t5_drain");
        check_output("t5_lo", mdi.lo, 32'd12);
        check_output("t5_hi", mdi.hi, 32'd0);

        // Start with a non-arithmetic op is ignored
        apply_stimulus(MD_MTHI, 1'b1, 32'hBAD0BAD0, 32'd1);
        tick("ill_start");
        check_output("ill_start_hi", mdi.hi, 32'd0);
        apply_stimulus(MD_NONE, 1'b0, 32'd0, 32'd0);

        // Async reset in the middle of a divide
        apply_stimulus(MD_MTHI, 1'b0, 32'hAAAA, 32'd0);
        tick("t1_mthi");
        apply_stimulus(MD_MTLO, 1'b0, 32'h5555, 32'd0);
        tick("t1_mtlo");
        apply_stimulus(MD_DIV, 1'b1, 32'd100, 32'd7);
        tick("t1_div");
        apply_stimulus(MD_NONE, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) tick("t1_run");
        #1;
        reset = 1'b0;
        #1;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        pend_left = 0;
        check_output("t1_rst_busy", {31'd0, mdi.busy}, 32'd0);
        check_output("t1_rst_hi", mdi.hi, 32'd0);
        check_output("t1_rst_lo", mdi.lo, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("t1_hold_busy", {31'd0, mdi.busy}, 32'd0);
        check_output("t1_hold_hi", mdi.hi, 32'd0);
        #1;
        reset = 1'b1;
        run_op("t1_after", MD_DIV, 32'd100, 32'd7, DIV_N, 1'b0);
        check_output("t1_after_lo", mdi.lo, 32'd14);
        check_output("t1_after_hi", mdi.hi, 32'd2);

        // Operands toggled during the run; then back-to-back start
        run_op("t6_mult", MD_MULT, 32'h12345678, 32'h9ABCDEF0, MULT_N, 1'b1);
        apply_stimulus(MD_MULTU, 1'b1, 32'hCAFEF00D, 32'h0000BEEF);
        tick("t6_b2b");
        check_output("t6_b2b_busy", {31'd0, mdi.busy}, 32'd1);
        apply_stimulus(MD_NONE, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 20 && pend_left > 0; i++) tick("t6_drain");

        // Random traffic, including illegal requests while busy
        for (int k = 0; k < 60; k++) begin
            int          sel;
            logic [31:0] ra;
            logic [31:0] rb;
            logic [3:0]  op;
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
            case (sel)
                0: op = MD_MULT;
                1: op = MD_MULTU;
                2: op = MD_DIV;
                3: op = MD_DIVU;
                4: op = MD_MTHI;
                5: op = MD_MTLO;
                6: op = MD_MFHI;
                default: op = MD_MFLO;
            endcase
            apply_stimulus(op, (sel < 4), ra, rb);
            tick("rnd");
            for (int g = 0; g < 20 && pend_left > 0; g++) begin
                int ns;
                ns = $urandom_range(0, 5);
                case (ns)
                    0: apply_stimulus(MD_MTHI, 1'b0, $urandom, $urandom);
                    1: apply_stimulus(MD_MTLO, 1'b0, $urandom, $urandom);
                    2: apply_stimulus(MD_MULT, 1'b1, $urandom, $urandom);
                    3: apply_stimulus(MD_MFHI, 1'b0, $urandom, $urandom);
                    4: apply_stimulus(MD_MFLO, 1'b0, $urandom, $urandom);
                    default: apply_stimulus(MD_NONE, 1'b0, $urandom, $urandom);
                endcase
                tick("rnd_run");
            end
            apply_stimulus(MD_NONE, 1'b0, 32'd0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
